upd7800_cpgen: RTL and testbench
================================

UPD7800_CPGEN -- requirements
Module: upd7800_cpgen

Interface
REQ-001 SHALL have parameter DIV, default 1; CLK cycles per phase step, legal range 1..16.
REQ-002 SHALL have parameter RESET_HOLD, default 16; full CP machine cycles that CPU_RESETB is held low after RES deasserts, legal range 1..255.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RES  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port CE  input  1  global clock enable; the prescaler advances only while CE=1.
REQ-006 SHALL have port STOP_REQ  input  1  request to freeze CPU clock phases (debugger/HALT).
REQ-007 SHALL have port STOP_ACK  output  1  phases frozen at a machine-cycle boundary.
REQ-008 SHALL have ports CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE  output  1 each  one-CLK-wide phase strobes to upd7800.
REQ-009 SHALL have port CPU_RESETB  output  1  active-low reset to upd7800 RESETB.
REQ-010 SHALL have port PHASE  output  2  index of the next strobe to issue: 0=CP1P, 1=CP1N, 2=CP2P, 3=CP2N.

Function
REQ-011 Prescaler SHALL count 0..DIV-1, incrementing on CLK edges with CE=1; it holds on CE=0.
REQ-012 A step SHALL occur when the prescaler is at DIV-1 with CE=1; the prescaler then wraps to 0.
REQ-013 On each step, the strobe selected by PHASE SHALL be registered high for exactly one CLK, and PHASE SHALL increment modulo 4.
REQ-014 Strobe order SHALL be CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE, repeating.
REQ-015 At most one strobe SHALL be high in any CLK.
REQ-016 With DIV=1 and CE=1, a strobe SHALL be high every CLK.
REQ-017 STOP_REQ SHALL be sampled at each step. If it is 1 when PHASE=0, the module SHALL issue no strobe, hold PHASE=0, hold the prescaler at 0, and set STOP_ACK=1 on the next CLK.
REQ-018 A stop SHALL take effect only at PHASE=0, i.e. after a CP2_NEGEDGE. A request raised mid-cycle SHALL complete the remaining strobes first.
REQ-019 While stopped, STOP_REQ=0 SHALL clear STOP_ACK on the next CLK. Stepping SHALL then resume from prescaler 0, with CP1_POSEDGE issued DIV enabled CLKs later.
REQ-020 STOP_REQ toggled while not at PHASE=0 SHALL have no effect until the next PHASE=0 step.
REQ-021 The reset-hold counter (8 bits) SHALL increment on each CP2_NEGEDGE strobe while CPU_RESETB=0.
REQ-022 When the reset-hold counter reaches RESET_HOLD, CPU_RESETB SHALL go 1 on the following CLK and remain 1 until RES.
REQ-023 Strobes SHALL run during the reset hold, so the CPU gets clocks while in reset.
REQ-024 The reset-hold counter SHALL freeze while stopped.
REQ-025 CE=0 SHALL freeze all state except STOP_ACK clearing. Strobes SHALL be 0 while CE=0.

Reset
REQ-026 While RES=1, asynchronously: all strobes=0, PHASE=0, prescaler=0, STOP_ACK=0, CPU_RESETB=0, reset-hold counter=0.
REQ-027 RES asserted mid-cycle or while stopped SHALL abort immediately. After release, stepping SHALL restart at CP1_POSEDGE and the full RESET_HOLD count SHALL restart.
REQ-028 On the first CLK after RES falls, the prescaler SHALL begin counting. With DIV=1, CP1_POSEDGE SHALL be high during the first CLK period after that edge.

Structure
REQ-029 The phase encoding (2-bit typedef cp_phase_t with constants CP1P, CP1N, CP2P, CP2N) SHALL live in shared package upd7800_pkg, for reuse by upd7800 and benches.
REQ-030 The prescaler SHALL be a sub-module named cpgen_prescaler (parameter DIV; ports CLK, RES, CE, HOLD, STEP). All other logic SHALL stay flat in upd7800_cpgen.

Verification
REQ-031 Scenario, free run: DIV=1, CE=1, RES released → strobes cycle CP1P, CP1N, CP2P, CP2N every CLK; checker flags any two simultaneous strobes.
REQ-032 Scenario, divider: DIV=3, CE=1 → each strobe is 1 CLK wide and strobes are spaced 3 CLKs apart; 12 CLKs per machine cycle.
REQ-033 Scenario, reset hold: RESET_HOLD=16, DIV=1 → CPU_RESETB rises exactly 1 CLK after the 16th CP2_NEGEDGE (CLK 64 after RES release).
REQ-034 Scenario, stop: STOP_REQ=1 asserted just after CP1_NEGEDGE → CP2P and CP2N still issue; then no strobes; STOP_ACK=1; drop STOP_REQ → STOP_ACK=0 next CLK, then CP1_POSEDGE.
REQ-035 Scenario, CE gating: CE toggled 1,0,1,0... with DIV=1 → strobes appear only on CE=1 CLKs, in correct order with none skipped.
REQ-036 Scenario, reset mid-stop: RES pulsed while STOP_ACK=1 → all outputs return to reset values and the reset-hold count restarts from 0.

Source files
------------

// File: rtl/upd7800_pkg.sv
// upd7800_pkg: phase encoding shared between the CPU core, its clock generator and benches
package upd7800_pkg;
  typedef enum logic [1:0] {CP1P, CP1N, CP2P, CP2N} cp_phase_t;
endpackage

// File: rtl/upd7800_cpgen_prescaler.sv
// cpgen_prescaler: divides CLK by DIV into single-cycle phase-step pulses, parked at 0 while HOLD
module cpgen_prescaler #(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RES,
  input  logic CE,
  input  logic HOLD,
  output logic STEP
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign STEP = CE && !HOLD && cnt == W'(DIV - 1);
  // count enabled clocks, wrapping to 0 on each step
  always_ff @(posedge CLK or posedge RES)
    if (RES) cnt <= '0;
    else if (CE && !HOLD) cnt <= STEP ? '0 : cnt + W'(1);
endmodule

// File: rtl/upd7800_cpgen.sv
// upd7800_cpgen: four-phase CP strobe generator with stop handshake and CPU reset hold
module upd7800_cpgen
  import upd7800_pkg::*;
#(
  parameter int DIV        = 1,
  parameter int RESET_HOLD = 16
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CE,
  input  logic       STOP_REQ,
  output logic       STOP_ACK,
  output logic       CP1_POSEDGE,
  output logic       CP1_NEGEDGE,
  output logic       CP2_POSEDGE,
  output logic       CP2_NEGEDGE,
  output logic       CPU_RESETB,
  output logic [1:0] PHASE
);
  cp_phase_t phase;
  logic [3:0] strobe;
  logic [7:0] hold_cnt;
  logic step, stop_now, fire;
  cpgen_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK (CLK),
    .RES (RES),
    .CE  (CE),
    .HOLD(STOP_ACK),
    .STEP(step)
  );
  assign stop_now = step && phase == CP1P && STOP_REQ;
  assign fire = step && !stop_now;
  assign {CP2_NEGEDGE, CP2_POSEDGE, CP1_NEGEDGE, CP1_POSEDGE} = strobe;
  assign PHASE = phase;
  // issue one strobe per step, park at a machine-cycle boundary on stop, release CPU reset after the hold
  always_ff @(posedge CLK or posedge RES)
    if (RES) begin
      phase      <= CP1P;
      strobe     <= '0;
      STOP_ACK   <= 1'b0;
      hold_cnt   <= '0;
      CPU_RESETB <= 1'b0;
    end else begin
      strobe <= fire ? 4'(1) << phase : '0;
      if (fire) phase <= cp_phase_t'(phase + 2'd1);
      if (STOP_ACK && !STOP_REQ) STOP_ACK <= 1'b0;
      else if (stop_now) STOP_ACK <= 1'b1;
      if (fire && phase == CP2N && !CPU_RESETB && hold_cnt != 8'(RESET_HOLD)) hold_cnt <= hold_cnt + 8'd1;
      if (CE && hold_cnt == 8'(RESET_HOLD)) CPU_RESETB <= 1'b1;
    end
endmodule

// File: tb/tb_upd7800_cpgen.sv
// tb_upd7800_cpgen: randomized and directed checks of two cpgen configurations against a machine-cycle model
module tb_upd7800_cpgen;
  logic clk = 1'b0, res = 1'b1, ce = 1'b0, stop_req = 1'b0;
  logic a_ack, a_p1p, a_p1n, a_p2p, a_p2n, a_rb;
  logic b_ack, b_p1p, b_p1n, b_p2p, b_p2n, b_rb;
  logic [1:0] a_ph, b_ph;
  logic [3:0] a_s, b_s;
  int tests = 0, fails = 0;
  int div[2] = '{1, 3};
  int rh[2] = '{16, 2};
  int pre[2], ph[2], ack[2], mcyc[2], rb[2], sb[2];
  always #5 clk = ~clk;
  assign a_s = {a_p2n, a_p2p, a_p1n, a_p1p};
  assign b_s = {b_p2n, b_p2p, b_p1n, b_p1p};

  upd7800_cpgen #(.DIV(1), .RESET_HOLD(16)) u_a (
    .CLK(clk), .RES(res), .CE(ce), .STOP_REQ(stop_req), .STOP_ACK(a_ack),
    .CP1_POSEDGE(a_p1p), .CP1_NEGEDGE(a_p1n), .CP2_POSEDGE(a_p2p), .CP2_NEGEDGE(a_p2n),
    .CPU_RESETB(a_rb), .PHASE(a_ph)
  );
  upd7800_cpgen #(.DIV(3), .RESET_HOLD(2)) u_b (
    .CLK(clk), .RES(res), .CE(ce), .STOP_REQ(stop_req), .STOP_ACK(b_ack),
    .CP1_POSEDGE(b_p1p), .CP1_NEGEDGE(b_p1n), .CP2_POSEDGE(b_p2p), .CP2_NEGEDGE(b_p2n),
    .CPU_RESETB(b_rb), .PHASE(b_ph)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      pre[i] = 0; ph[i] = 0; ack[i] = 0; mcyc[i] = 0; rb[i] = 0; sb[i] = -1;
    end
  endfunction

  // one CLK of behaviour: enabled clocks accumulate into steps, steps emit phases,
  // completed machine cycles count towards releasing the CPU reset
  function automatic void m_clk();
    for (int i = 0; i < 2; i++) begin
      if (res) begin
        pre[i] = 0; ph[i] = 0; ack[i] = 0; mcyc[i] = 0; rb[i] = 0; sb[i] = -1;
      end else begin
        bit running = ce && ack[i] == 0;
        bit stp = running && pre[i] == div[i] - 1;
        int done = mcyc[i];
        sb[i] = -1;
        if (running) pre[i] = (pre[i] + 1) % div[i];
        if (ack[i] != 0) begin
          if (!stop_req) ack[i] = 0;
        end else if (stp) begin
          if (ph[i] == 0 && stop_req) ack[i] = 1;
          else begin
            sb[i] = ph[i];
            ph[i] = (ph[i] + 1) % 4;
            if (sb[i] == 3 && rb[i] == 0 && mcyc[i] < rh[i]) mcyc[i]++;
          end
        end
        if (ce && done == rh[i]) rb[i] = 1;
      end
    end
  endfunction

  function automatic logic [7:0] m_exp(input int i);
    logic [3:0] s;
    s = sb[i] < 0 ? 4'd0 : 4'(1 << sb[i]);
    return {s, 2'(ph[i]), 1'(ack[i]), 1'(rb[i])};
  endfunction

  task automatic compare();
    check("dut_a", {a_s, a_ph, a_ack, a_rb}, m_exp(0));
    check("dut_b", {b_s, b_ph, b_ack, b_rb}, m_exp(1));
    check("onehot", ($countones(a_s) <= 1) && ($countones(b_s) <= 1), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    m_clk();
    #1;
    compare();
  endtask

  task automatic async_reset();
    res = 1'b1;
    m_reset();
    #1;
    compare();
    check("rst_all", {a_s, a_ph, a_ack, a_rb, b_s, b_ph, b_ack, b_rb}, 0);
  endtask

  initial begin
    int n;
    m_reset();
    tick();
    tick();
    check("rst_vals", {a_s, a_ph, a_ack, a_rb}, 0);
    res = 1'b0;
    ce = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 1) check("cp1p_first", a_p1p, 1);
      if (k == 2) check("div3_idle", b_s, 0);
      if (k == 3) check("div3_cp1p", b_p1p, 1);
      if (k == 6) check("div3_cp1n", b_p1n, 1);
      if (k == 64) check("rb_hold_64", a_rb, 0);
      if (k == 65) check("rb_rise_65", a_rb, 1);
    end
    n = 0;
    while (a_ph != 2'd2 && n < 8) begin tick(); n++; end
    check("align_to", n < 8, 1);
    stop_req = 1'b1;
    tick();
    check("stop_cp2p", a_p2p, 1);
    tick();
    check("stop_cp2n", a_p2n, 1);
    tick();
    check("stop_ack", {a_ack, a_s}, 5'h10);
    for (int k = 0; k < 4; k++) tick();
    check("stopped_quiet", {a_ack, a_s, a_ph}, 7'h40);
    stop_req = 1'b0;
    tick();
    check("ack_clear", {a_ack, a_s}, 0);
    tick();
    check("resume_cp1p", a_p1p, 1);
    stop_req = 1'b1;
    n = 0;
    while (!a_ack && n < 20) begin tick(); n++; end
    check("stop_to", a_ack, 1);
    async_reset();
    tick();
    res = 1'b0;
    stop_req = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 64) check("rb_restart_64", a_rb, 0);
      if (k == 65) check("rb_restart_65", a_rb, 1);
    end
    for (int k = 0; k < 40; k++) begin
      ce = ~ce;
      tick();
    end
    ce = 1'b1;
    for (int k = 0; k < 800; k++) begin
      if (res) res = 1'b0;
      ce = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) stop_req = ~stop_req;
      if ($urandom_range(0, 199) == 0) async_reset();
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
